eth_avalon_sc_fifo: RTL and testbench

//  Single-clock show-ahead FIFO for the eth_avalon DMA paths (TX/RX data and descriptor buffering).

---
 rtl/eth_avalon_sc_fifo.sv | 107 ++++++++++
 tb/tb_eth_avalon_sc_fifo.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/eth_avalon_sc_fifo.sv
// Single-clock show-ahead FIFO for eth_avalon DMA paths.
// Full-range usedw, programmable level flags, flush and sticky error flags.
module eth_avalon_sc_fifo #(
    parameter int WIDTH    = 36,
    parameter int DEPTH    = 1024,
    parameter int AF_LEVEL = DEPTH - 4,
    parameter int AE_LEVEL = 4,
    parameter bit PROTECT  = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       data,
    input  logic                   wrreq,
    input  logic                   rdreq,
    output logic [WIDTH-1:0]       q,
    output logic                   empty,
    output logic                   full,
    output logic                   almost_empty,
    output logic                   almost_full,
    output logic [$clog2(DEPTH):0] usedw,
    output logic                   overflow,
    output logic                   underflow,
    input  logic                   err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int UW = AW + 1;
    localparam logic [UW-1:0] FULL_CNT = UW'(DEPTH);
    localparam logic [UW-1:0] AF_CNT   = UW'(AF_LEVEL);
    localparam logic [UW-1:0] AE_CNT   = UW'(AE_LEVEL);
    localparam logic          PROT     = PROTECT;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [UW-1:0]    usedw_nxt;
    logic             wr_ok;
    logic             rd_ok;
    logic             ov_set;
    logic             un_set;

    always_comb begin
        wr_ok     = wrreq & ~flush & (~full | rdreq | ~PROT);
        rd_ok     = rdreq & ~flush & (~empty | ~PROT);
        ov_set    = PROT & ~flush & wrreq & full & ~rdreq;
        un_set    = PROT & ~flush & rdreq & empty;
        usedw_nxt = usedw + UW'(wr_ok) - UW'(rd_ok);
        if (flush) begin
            usedw_nxt = '0;
        end
    end

    // Storage has no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_ok && reset_n) begin
            mem[wr_ptr] <= data;
        end
    end

    assign q = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            usedw        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
        end else if (flush) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            usedw        <= '0;
            empty        <= 1'b1;
            full         <= 1'b0;
            almost_empty <= 1'b1;
            almost_full  <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            // Flags come from the next count so they never lag usedw.
            usedw        <= usedw_nxt;
            empty        <= (usedw_nxt == '0);
            full         <= (usedw_nxt == FULL_CNT);
            almost_empty <= (usedw_nxt <= AE_CNT);
            almost_full  <= (usedw_nxt >= AF_CNT);
        end
    end

    // A new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= ov_set | (overflow & ~err_clr);
            underflow <= un_set | (underflow & ~err_clr);
        end
    end

endmodule

// File: tb/tb_eth_avalon_sc_fifo.sv
// Scoreboard bench for eth_avalon_sc_fifo (DEPTH=8, PROTECT=1).
// Queue reference model for contents, count and error flags.
module tb_eth_avalon_sc_fifo;

    localparam int W  = 16;
    localparam int D  = 8;
    localparam int AF = 4;
    localparam int AE = 2;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b0;
    logic         flush   = 1'b0;
    logic         wrreq   = 1'b0;
    logic         rdreq   = 1'b0;
    logic         err_clr = 1'b0;
    logic [W-1:0] data    = '0;
    logic [W-1:0] q;
    logic         empty;
    logic         full;
    logic         almost_empty;
    logic         almost_full;
    logic         overflow;
    logic         underflow;
    logic [3:0]   usedw;

    int checks = 0;
    int passed = 0;

    logic [W-1:0] exp_data[$];
    logic [9:0]   exp_stat[$];
    int           cnt = 0;
    bit           ov  = 1'b0;
    bit           un  = 1'b0;

    eth_avalon_sc_fifo #(
        .WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE), .PROTECT(1'b1)
    ) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush), .data(data),
        .wrreq(wrreq), .rdreq(rdreq), .q(q), .empty(empty), .full(full),
        .almost_empty(almost_empty), .almost_full(almost_full),
        .usedw(usedw), .overflow(overflow), .underflow(underflow),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Drive one cycle, then advance the model for the coming edge.
    task automatic step(input bit rn, input bit fl, input bit wr,
                        input bit rd, input logic [W-1:0] d, input bit ec);
        bit rok;
        bit wok;
        @(negedge clk);
        reset_n = rn;
        flush   = fl;
        wrreq   = wr;
        rdreq   = rd;
        data    = d;
        err_clr = ec;
        #2;
        if (!rn) begin
            cnt = 0;
            ov  = 1'b0;
            un  = 1'b0;
            exp_data.delete();
        end else if (fl) begin
            cnt = 0;
            ov  = ov && !ec;
            un  = un && !ec;
            exp_data.delete();
        end else begin
            rok = rd && (cnt > 0);
            wok = wr && ((cnt < D) || rd);
            ov  = (ov && !ec) || (wr && cnt == D && !rd);
            un  = (un && !ec) || (rd && cnt == 0);
            if (wok) exp_data.push_back(d);
            cnt = cnt + int'(wok) - int'(rok);
        end
        exp_stat.push_back({4'(cnt), cnt == 0, cnt == D,
                            cnt <= AE, cnt >= AF, ov, un});
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    endtask

    // Head-of-queue monitor, sampled just after inputs settle.
    initial forever begin
        @(negedge clk);
        #1;
        if (empty === 1'b0) begin
            if (exp_data.size() == 0) begin
                check("q_head_nodata", 32'(q), 32'hFFFF_FFFF);
            end else begin
                check("q_head", 32'(q), 32'(exp_data[0]));
                if (rdreq && reset_n && !flush) exp_data.delete(0);
            end
        end
    end

    // Status monitor, sampled 1 time unit after each edge.
    initial forever begin
        logic [9:0] e;
        @(posedge clk);
        #1;
        if (exp_stat.size() > 0) begin
            e = exp_stat.pop_front();
            check("status", 32'({usedw, empty, full, almost_empty,
                                 almost_full, overflow, underflow}), 32'(e));
        end
    end

    initial begin
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        // fill to full, drain in order
        for (int i = 1; i <= 8; i++) step(1'b1, 1'b0, 1'b1, 1'b0, W'(i), 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 1'b1, '0, 1'b0);
        // overflow while full, then clear
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 1'b0, W'(16 + i), 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h00AA, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 1'b1, '0, 1'b0);
        // read+write on empty
        step(1'b1, 1'b0, 1'b1, 1'b1, 16'h0055, 1'b0);
        idle();
        step(1'b1, 1'b0, 1'b0, 1'b1, '0, 1'b1);
        // full with simultaneous read/write across pointer wrap
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 1'b0, W'(32 + i), 1'b0);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 1'b1, 1'b1, W'(48 + i), 1'b0);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 1'b1, '0, 1'b0);
        // flush keeps error flags
        step(1'b1, 1'b0, 1'b0, 1'b1, '0, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0, W'(80 + i), 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 16'h0099, 1'b0);
        idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b1);
        // reset mid-burst
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 1'b0, W'(96 + i), 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0BAD, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0, 16'h0077, 1'b0);
        idle();
        step(1'b1, 1'b0, 1'b0, 1'b1, '0, 1'b0);
        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(999) > 3),
                 ($urandom_range(99) == 0),
                 ($urandom_range(99) < 55),
                 ($urandom_range(99) < 50),
                 W'($urandom),
                 ($urandom_range(99) < 5));
        end
        idle();
        idle();
        repeat (4) @(posedge clk);
        #2;
        check("stat_queue_drained", 32'(exp_stat.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
